// File: rtl/clk_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : clk_reset_sequencer
// Brief   : Orders MMCM lock, IDELAYCTRL reset/ready and datapath reset
//           release, re-resetting the MMCM on timeout or lock loss.
// Revision: 1.0  initial release
// ============================================================================
module clk_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int IDELAY_RST_CYCLES   = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RETRY_PULSE_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       glbl_rst,
  input  logic       dcm_locked,
  input  logic       idelayctrl_rdy,
  output logic       mmcm_rst_req,
  output logic       idelayctrl_rst,
  output logic       gtx_rst,
  output logic       seq_done,
  output logic [7:0] lock_loss_cnt,
  output logic       timeout_err
);

  localparam int MAX_AB = (LOCK_STABLE_CYCLES > IDELAY_RST_CYCLES) ? LOCK_STABLE_CYCLES : IDELAY_RST_CYCLES;
  localparam int MAX_CD = (LOCK_TIMEOUT_CYCLES > RETRY_PULSE_CYCLES) ? LOCK_TIMEOUT_CYCLES : RETRY_PULSE_CYCLES;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = (MAX_P > 2) ? $clog2(MAX_P) : 1;

  // The WAIT_LOCK cycle that first sees lock already counts toward stability,
  // so STABLE itself only has to cover the remaining LOCK_STABLE_CYCLES-1.
  localparam logic [CW-1:0] C_STABLE_LAST  = CW'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam logic [CW-1:0] C_IDELAY_LAST  = CW'(IDELAY_RST_CYCLES - 1);
  localparam logic [CW-1:0] C_TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_PULSE_LAST   = CW'(RETRY_PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RST        = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_STABLE     = 3'd2,
    S_IDELAY_RST = 3'd3,
    S_WAIT_RDY   = 3'd4,
    S_RUN        = 3'd5,
    S_RETRY      = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      lock_sync_q, rdy_sync_q;
  logic [7:0]      lock_loss_q, lock_loss_d;
  logic            timeout_err_q, timeout_err_d;
  logic            locked_s, rdy_s;
  logic            timeout_hit, loss_hit;

  assign locked_s = lock_sync_q[1];
  assign rdy_s    = rdy_sync_q[1];

  always_ff @(posedge clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      lock_sync_q <= 2'b00;
      rdy_sync_q  <= 2'b00;
    end else begin
      lock_sync_q <= {lock_sync_q[0], dcm_locked};
      rdy_sync_q  <= {rdy_sync_q[0], idelayctrl_rdy};
    end
  end

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    loss_hit    = 1'b0;
    case (state_q)
      S_RST: state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (locked_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == C_TIMEOUT_LAST) begin
          state_d     = S_RETRY;
          timeout_hit = 1'b1;
        end
      end
      S_STABLE: begin
        if (!locked_s)                    state_d = S_WAIT_LOCK;
        else if (cnt_q == C_STABLE_LAST)  state_d = S_IDELAY_RST;
      end
      S_IDELAY_RST: begin
        if (!locked_s)                    state_d = S_WAIT_LOCK;
        else if (cnt_q == C_IDELAY_LAST)  state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
        end else if (rdy_s) begin
          state_d = S_RUN;
        end else if (cnt_q == C_TIMEOUT_LAST) begin
          state_d     = S_RETRY;
          timeout_hit = 1'b1;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d  = S_RETRY;
          loss_hit = 1'b1;
        end
      end
      S_RETRY: begin
        if (cnt_q == C_PULSE_LAST) state_d = S_WAIT_LOCK;
      end
      default: state_d = S_RST;
    endcase
  end

  // Shared counter restarts on every state change; RUN has no deadline so it holds.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (state_d != state_q)    cnt_d = '0;
    else if (state_q == S_RUN) cnt_d = cnt_q;
  end

  always_comb begin
    lock_loss_d   = lock_loss_q;
    timeout_err_d = timeout_err_q | timeout_hit;
    if (loss_hit && (lock_loss_q != 8'hFF)) lock_loss_d = lock_loss_q + 8'd1;
  end

  always_ff @(posedge clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      state_q       <= S_RST;
      cnt_q         <= '0;
      lock_loss_q   <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lock_loss_q   <= lock_loss_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mmcm_rst_req   = (state_q == S_RETRY);
  assign idelayctrl_rst = (state_q != S_WAIT_RDY) && (state_q != S_RUN);
  assign gtx_rst        = (state_q != S_RUN);
  assign seq_done       = (state_q == S_RUN);
  assign lock_loss_cnt  = lock_loss_q;
  assign timeout_err    = timeout_err_q;

endmodule
`default_nettype wire
